// File: rtl/sim_cycle_watchdog.sv
// sim_cycle_watchdog: run controller for the simulation harness.
// It latches a total-cycle limit and a no-progress limit once out of reset.
// It counts run cycles and idle cycles, then settles in a sticky PASS on the
// success strobe or a sticky FAIL when a limit expires.
// A limit value of zero disables that limit.
// Optional feature macro: WATCHDOG_FATAL_EN. When it is defined and SYNTHESIS
// is not defined, the block reports the verdict with $fatal / $display.
module sim_cycle_watchdog #(
    parameter int CNT_W = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      cfg_max_cycles,
    input  logic [31:0]      cfg_idle_limit,
    input  logic             progress,
    input  logic             success,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_MAX  = 2'd1;
    localparam logic [1:0] CODE_IDLE = 2'd2;

    // Increment that pins at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] max_sh_r;
    logic [CNT_W-1:0] max_sh_s;
    logic [CNT_W-1:0] idle_sh_r;
    logic [CNT_W-1:0] idle_sh_s;
    logic [CNT_W-1:0] cycle_count_r;
    logic [CNT_W-1:0] cycle_count_s;
    logic [CNT_W-1:0] idle_cnt_r;
    logic [CNT_W-1:0] idle_cnt_s;
    logic             done_r;
    logic             done_s;
    logic             pass_r;
    logic             pass_s;
    logic             fail_r;
    logic             fail_s;
    logic [1:0]       fail_code_r;
    logic [1:0]       fail_code_s;
    logic             max_hit_s;
    logic             idle_hit_s;

    // Limit-expiry conditions, taken from the current register values.
    always_comb begin
        max_hit_s  = (max_sh_r != CNT_ZERO) && (cycle_count_r == (max_sh_r - CNT_ONE));
        idle_hit_s = (idle_sh_r != CNT_ZERO) && !progress &&
                     (idle_cnt_r == (idle_sh_r - CNT_ONE));
    end

    // State register; reset returns to INIT from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; success outranks both limits, PASS/FAIL are terminal.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (success) begin
                    state_s = ST_PASS;
                end else if (max_hit_s || idle_hit_s) begin
                    state_s = ST_FAIL;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PASS: begin
                state_s = ST_PASS;
            end
            ST_FAIL: begin
                state_s = ST_FAIL;
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Next values of the limits, counters and verdict outputs.
    always_comb begin
        max_sh_s      = max_sh_r;
        idle_sh_s     = idle_sh_r;
        cycle_count_s = cycle_count_r;
        idle_cnt_s    = idle_cnt_r;
        fail_code_s   = fail_code_r;
        case (state_r)
            ST_INIT: begin
                max_sh_s      = CNT_W'(cfg_max_cycles);
                idle_sh_s     = CNT_W'(cfg_idle_limit);
                cycle_count_s = CNT_ZERO;
                idle_cnt_s    = CNT_ZERO;
            end
            ST_RUN: begin
                cycle_count_s = sat_inc(cycle_count_r);
                if (progress) begin
                    idle_cnt_s = CNT_ZERO;
                end else begin
                    idle_cnt_s = sat_inc(idle_cnt_r);
                end
                // The max-cycle limit wins when both limits expire together.
                if (!success && max_hit_s) begin
                    fail_code_s = CODE_MAX;
                end else if (!success && idle_hit_s) begin
                    fail_code_s = CODE_IDLE;
                end else begin
                    fail_code_s = fail_code_r;
                end
            end
            default: begin
                // PASS and FAIL freeze everything.
                cycle_count_s = cycle_count_r;
            end
        endcase
        done_s = (state_s == ST_PASS) || (state_s == ST_FAIL);
        pass_s = (state_s == ST_PASS);
        fail_s = (state_s == ST_FAIL);
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            max_sh_r      <= CNT_ZERO;
            idle_sh_r     <= CNT_ZERO;
            cycle_count_r <= CNT_ZERO;
            idle_cnt_r    <= CNT_ZERO;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            fail_code_r   <= CODE_NONE;
        end else begin
            max_sh_r      <= max_sh_s;
            idle_sh_r     <= idle_sh_s;
            cycle_count_r <= cycle_count_s;
            idle_cnt_r    <= idle_cnt_s;
            done_r        <= done_s;
            pass_r        <= pass_s;
            fail_r        <= fail_s;
            fail_code_r   <= fail_code_s;
        end
    end

    assign cycle_count = cycle_count_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign fail        = fail_r;
    assign fail_code   = fail_code_r;

`ifdef WATCHDOG_FATAL_EN
`ifndef SYNTHESIS
    // Report the verdict once, on the edge that enters PASS or FAIL.
    always @(posedge clock) begin
        if (!reset && (state_r == ST_RUN) && (state_s == ST_FAIL)) begin
            $fatal(1, "watchdog: FAIL fail_code=%0d at cycle %0d", fail_code_s, cycle_count_s);
        end else if (!reset && (state_r == ST_RUN) && (state_s == ST_PASS)) begin
            $display("watchdog: PASS at cycle %0d", cycle_count_s);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_sim_cycle_watchdog.sv
// Testbench for sim_cycle_watchdog.
// A table of directed run scenarios is followed by hand-written sequences for
// the reset, config-change and no-limit cases.
// Edge k means the k-th rising edge after reset is released, and edge 1 is the
// INIT cycle.
module tb_sim_cycle_watchdog;

    localparam int CNT_W = 40;

    logic             clock;
    logic             reset;
    logic [31:0]      cfg_max_cycles;
    logic [31:0]      cfg_idle_limit;
    logic             progress;
    logic             success;
    logic [CNT_W-1:0] cycle_count;
    logic             done;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;

    int checks;
    int failures;

    sim_cycle_watchdog #(.CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_max_cycles (cfg_max_cycles),
        .cfg_idle_limit (cfg_idle_limit),
        .progress       (progress),
        .success        (success),
        .cycle_count    (cycle_count),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .fail_code      (fail_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] max_c;
        logic [31:0] idle_c;
        int          prog_period;   // progress on edges that are multiples of this (0 = never)
        int          prog_until;    // last edge that may carry progress
        int          success_edge;  // edge on which success is high (0 = never)
        int          chg_edge;      // edge from which cfg_max_cycles is changed (0 = never)
        logic [31:0] chg_val;
        logic        exp_pass;
        logic        exp_fail;
        logic [1:0]  exp_code;
        logic [63:0] exp_cc;
        int          exp_edge;      // edge on which done first rises
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " pass"}, 64'(pass), 64'd0);
        chk({tag, " fail"}, 64'(fail), 64'd0);
        chk({tag, " fail_code"}, 64'(fail_code), 64'd0);
        chk({tag, " cycle_count"}, 64'(cycle_count), 64'd0);
    endtask

    // Reset, load the config, release reset and run until done (bounded).
    task automatic run_vec(input vec_t v, output int edge_o);
        edge_o         = 0;
        reset          = 1'b1;
        progress       = 1'b0;
        success        = 1'b0;
        cfg_max_cycles = v.max_c;
        cfg_idle_limit = v.idle_c;
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            progress = (v.prog_period != 0) && (k % v.prog_period == 0) && (k <= v.prog_until);
            success  = (k == v.success_edge);
            if (v.chg_edge != 0 && k >= v.chg_edge) cfg_max_cycles = v.chg_val;
            step();
            if (done) begin
                edge_o = k;
                break;
            end
        end
        progress = 1'b0;
        success  = 1'b0;
    endtask

    task automatic check_vec(input vec_t v, input int edge_seen);
        chk({v.name, " done_edge"}, 64'(edge_seen), 64'(v.exp_edge));
        chk({v.name, " pass"}, 64'(pass), 64'(v.exp_pass));
        chk({v.name, " fail"}, 64'(fail), 64'(v.exp_fail));
        chk({v.name, " fail_code"}, 64'(fail_code), 64'(v.exp_code));
        chk({v.name, " cycle_count"}, 64'(cycle_count), v.exp_cc);
        // Terminal states must ignore inputs and hold their outputs.
        progress       = 1'b1;
        success        = 1'b1;
        cfg_max_cycles = 32'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            progress = ~progress;
        end
        progress = 1'b0;
        success  = 1'b0;
        chk({v.name, " hold done"}, 64'(done), 64'd1);
        chk({v.name, " hold pass"}, 64'(pass), 64'(v.exp_pass));
        chk({v.name, " hold fail"}, 64'(fail), 64'(v.exp_fail));
        chk({v.name, " hold code"}, 64'(fail_code), 64'(v.exp_code));
        chk({v.name, " hold cc"}, 64'(cycle_count), v.exp_cc);
    endtask

    vec_t vecs[8];
    vec_t v;
    int   edge_seen;

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        progress       = 1'b0;
        success        = 1'b0;
        cfg_max_cycles = 32'd0;
        cfg_idle_limit = 32'd0;

        //         name          max    idle   per  until succ chg  chgval pass  fail  code  cc      edge
        vecs[0] = '{"max10",      32'd10, 32'd0, 0,  0,   0,   0,   32'd0, 1'b0, 1'b1, 2'd1, 64'd10, 11};
        vecs[1] = '{"idle5",      32'd0,  32'd5, 4,  40,  0,   0,   32'd0, 1'b0, 1'b1, 2'd2, 64'd44, 45};
        vecs[2] = '{"succ_at19",  32'd20, 32'd0, 0,  0,   21,  0,   32'd0, 1'b1, 1'b0, 2'd0, 64'd20, 21};
        vecs[3] = '{"both8",      32'd8,  32'd8, 0,  0,   0,   0,   32'd0, 1'b0, 1'b1, 2'd1, 64'd8,  9};
        vecs[4] = '{"idle3_save", 32'd0,  32'd3, 4,  4,   0,   0,   32'd0, 1'b0, 1'b1, 2'd2, 64'd6,  7};
        vecs[5] = '{"max1",       32'd1,  32'd0, 0,  0,   0,   0,   32'd0, 1'b0, 1'b1, 2'd1, 64'd1,  2};
        vecs[6] = '{"succ_idle",  32'd0,  32'd2, 0,  0,   3,   0,   32'd0, 1'b1, 1'b0, 2'd0, 64'd2,  3};
        vecs[7] = '{"succ_init",  32'd5,  32'd0, 0,  0,   1,   0,   32'd0, 1'b0, 1'b1, 2'd1, 64'd5,  6};

        // Reset state.
        step();
        step();
        check_cleared("reset");

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], edge_seen);
            check_vec(vecs[i], edge_seen);
        end

        // Changing cfg mid-run has no effect; reset from FAIL re-samples it.
        v = '{"cfg_chg", 32'd6, 32'd0, 0, 0, 0, 3, 32'd3, 1'b0, 1'b1, 2'd1, 64'd6, 7};
        run_vec(v, edge_seen);
        chk("cfg_chg done_edge", 64'(edge_seen), 64'd7);
        chk("cfg_chg cycle_count", 64'(cycle_count), 64'd6);
        chk("cfg_chg fail_code", 64'(fail_code), 64'd1);
        cfg_max_cycles = 32'd3;
        reset          = 1'b1;
        step();
        check_cleared("reset_from_fail");
        v = '{"resample3", 32'd3, 32'd0, 0, 0, 0, 0, 32'd0, 1'b0, 1'b1, 2'd1, 64'd3, 4};
        run_vec(v, edge_seen);
        check_vec(v, edge_seen);

        // Reset in the middle of RUN clears the counters.
        reset          = 1'b1;
        cfg_max_cycles = 32'd10;
        cfg_idle_limit = 32'd0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("midrun cycle_count", 64'(cycle_count), 64'd4);
        reset = 1'b1;
        step();
        check_cleared("reset_mid_run");

        // Both limits disabled: run indefinitely, never done.
        cfg_max_cycles = 32'd0;
        cfg_idle_limit = 32'd0;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            success = 1'b0;
            step();
        end
        chk("nolimit done", 64'(done), 64'd0);
        chk("nolimit fail", 64'(fail), 64'd0);
        chk("nolimit cycle_count", 64'(cycle_count), 64'd49);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_cycle_watchdog.md
Name: sim_cycle_watchdog

Overview:
Simulation run controller for the test harness. It takes the two limit values produced by the harness's plusarg readers: a total-cycle limit (+max_cycles) and a no-progress limit (+idle_cycles). It latches both once out of reset, counts run cycles and idle cycles, and declares PASS on a success strobe or FAIL on limit expiry. Pass/fail outputs are sticky and feed the harness's finish/error logic.

Parameters:
CNT_W, 40, width of the total and idle counters; legal range 32..64; 32-bit config inputs are zero-extended to CNT_W.

Ports:
clock  input  1  harness clock
reset  input  1  synchronous, active-high reset
cfg_max_cycles  input  32  total-cycle limit; 0 = disabled; sampled only in INIT
cfg_idle_limit  input  32  idle-cycle limit; 0 = disabled; sampled only in INIT
progress  input  1  single-cycle forward-progress pulse (e.g. retire or TileLink beat)
success  input  1  test-passed strobe from the DUT (e.g. tohost write)
cycle_count  output  CNT_W  RUN cycles elapsed
done  output  1  high in PASS or FAIL
pass  output  1  high in PASS
fail  output  1  high in FAIL
fail_code  output  2  0 = none, 1 = max-cycle limit, 2 = idle limit, 3 = reserved (never driven)

Behaviour:
- Reset values: state=INIT; cycle_count=0; idle_cnt=0; shadow limits=0; done=pass=fail=0; fail_code=0.
- All outputs are registered. No combinational path from any input to any output.
- State machine: INIT -> RUN -> {PASS | FAIL}. PASS and FAIL are terminal until reset.
- INIT (first cycle with reset low):
  - latch cfg_max_cycles into max_sh and cfg_idle_limit into idle_sh;
  - counters stay 0; progress and success are ignored;
  - next state RUN.
- RUN, evaluated each cycle on current register values; first matching rule wins:
  1. success=1 -> PASS; cycle_count still increments on this edge.
  2. max_sh!=0 and cycle_count==max_sh-1 -> FAIL, fail_code=1.
  3. idle_sh!=0 and progress=0 and idle_cnt==idle_sh-1 -> FAIL, fail_code=2.
  4. Otherwise stay in RUN.
- Counter updates in RUN:
  - cycle_count increments by 1 each cycle, saturating at all-ones (no wrap).
  - idle_cnt clears to 0 on progress=1; otherwise it increments, saturating.
- Resulting timing: fail rises on the edge where cycle_count becomes max_sh, i.e. max_sh+1 cycles after reset deasserts.
- Simultaneous events:
  - success together with a limit hit -> PASS;
  - both limits hit in the same cycle -> fail_code=1;
  - progress in the cycle where idle_cnt==idle_sh-1 prevents the idle fail.
- PASS/FAIL:
  - counters freeze; inputs are ignored; outputs hold.
  - done=1. pass and fail are mutually exclusive.
- cfg inputs are ignored after INIT: changing them mid-run has no effect.
- Reset asserted in any state, including mid-RUN or in PASS/FAIL: returns to INIT on the next edge with all reset values; limits are re-sampled afterwards.
- Saturation: with both limits 0, the block stays in RUN indefinitely and cycle_count pins at 2^CNT_W-1.

Optional Feature:
Macro WATCHDOG_FATAL_EN.
- Defined, and SYNTHESIS not defined:
  - on entry to FAIL, the block issues one $fatal message containing fail_code and cycle_count;
  - on entry to PASS, it issues one $display "watchdog: PASS at cycle N".
- Not defined, or SYNTHESIS defined: no system tasks; behaviour is signal-only and identical otherwise.

Test Plan:
- max=10, idle=0, no success -> fail=1, fail_code=1, cycle_count=10, first high 11 cycles after reset deasserts; holds thereafter.
- max=0, idle=5, progress every 4 cycles for 40 cycles, then none -> no fail while pulsing; fail_code=2 on the 5th consecutive idle RUN cycle's edge.
- max=20, success asserted on the cycle where cycle_count=19 -> pass=1, fail=0, cycle_count=20.
- max=8, idle=8, progress never -> both limits hit on the same cycle -> fail_code=1.
- Start with max=6; change cfg_max_cycles to 3 at cycle 2 of RUN -> fail at cycle_count=6. Then assert reset with max=3 -> outputs cleared; fail at cycle_count=3.
- max=0, idle=0, CNT_W=32, force cycle_count near 2^32-2 -> cycle_count saturates at 0xFFFFFFFF, no fail.
